// File: rtl/weighted_rr_lock_arbiter.sv
// ============================================================================
// Module   : weighted_rr_lock_arbiter
// Brief    : Round-robin arbiter that locks the grant until done, request
//            drop or a hold limit, with a saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module weighted_rr_lock_arbiter #(
  parameter int N_REQ    = 5,
  parameter int HOLD_MAX = 16,
  parameter int CNT_W    = 16,
  localparam int IW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IW-1:0]    grant_idx,
  output logic             conflict,
  output logic [CNT_W-1:0] conflict_cnt,
  output logic             timeout
);

  localparam int HW = $clog2(HOLD_MAX);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [N_REQ-1:0] c_ONE       = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]    c_LAST      = IW'(N_REQ - 1);
  localparam logic [HW-1:0]    c_HOLD_LAST = HW'(HOLD_MAX - 1);

  logic [0:0]       r_state;
  logic [IW-1:0]    r_ptr;
  logic [HW-1:0]    r_hold;
  logic [N_REQ-1:0] r_grant;
  logic             r_valid;
  logic [IW-1:0]    r_idx;
  logic             r_timeout;
  logic [CNT_W-1:0] r_cnt;

  logic             w_conflict;
  logic             w_any;
  logic             w_own_req;
  logic             w_limit;
  logic             w_release;
  logic             w_timeout;
  logic [IW-1:0]    w_ptr_inc;
  logic [IW-1:0]    w_arb_ptr;
  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_upper;
  logic [IW-1:0]    w_sel;

  function automatic logic [IW-1:0] f_lowest(input logic [N_REQ-1:0] v);
    f_lowest = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) f_lowest = i[IW-1:0];
    end
  endfunction

  // Two or more bits set <=> clearing the lowest set bit leaves something.
  assign w_conflict = |(req & (req - c_ONE));
  assign w_any      = |req;

  assign w_own_req  = req[r_idx];
  assign w_limit    = (r_hold == c_HOLD_LAST);
  assign w_release  = (r_state == S_GRANT) && (done || !w_own_req || w_limit);
  assign w_timeout  = (r_state == S_GRANT) && !done && w_own_req && w_limit;
  assign w_ptr_inc  = (r_idx == c_LAST) ? '0 : r_idx + IW'(1);

  // On release the scan already starts past the released requester.
  assign w_arb_ptr  = (r_state == S_GRANT) ? w_ptr_inc : r_ptr;
  assign w_mask     = ~((c_ONE << w_arb_ptr) - c_ONE);
  assign w_upper    = req & w_mask;
  assign w_sel      = (|w_upper) ? f_lowest(w_upper) : f_lowest(req);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_timeout <= 1'b0;
      if (w_conflict && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_grant <= c_ONE << w_sel;
            r_valid <= 1'b1;
            r_idx   <= w_sel;
            r_hold  <= '0;
          end
        end
        default: begin
          if (w_release) begin
            r_ptr     <= w_ptr_inc;
            r_timeout <= w_timeout;
            r_hold    <= '0;
            if (w_any) begin
              r_grant <= c_ONE << w_sel;
              r_valid <= 1'b1;
              r_idx   <= w_sel;
            end else begin
              r_state <= S_IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
              r_idx   <= '0;
            end
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
      endcase
    end
  end

  assign grant        = r_grant;
  assign grant_valid  = r_valid;
  assign grant_idx    = r_idx;
  assign timeout      = r_timeout;
  assign conflict     = w_conflict;
  assign conflict_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_weighted_rr_lock_arbiter.sv
// ============================================================================
// Module   : tb_weighted_rr_lock_arbiter
// Brief    : Scoreboard bench for weighted_rr_lock_arbiter (N=5, HOLD=4, CNT=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_weighted_rr_lock_arbiter;

  localparam int N    = 5;
  localparam int HOLD = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          arst_n;
  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [2:0]    grant_idx;
  logic          conflict;
  logic [CW-1:0] conflict_cnt;
  logic          timeout;

  weighted_rr_lock_arbiter #(.N_REQ(N), .HOLD_MAX(HOLD), .CNT_W(CW)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .conflict     (conflict),
    .conflict_cnt (conflict_cnt),
    .timeout      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  grant;
    logic [2:0]    idx;
    logic          valid;
    logic          to;
    logic [CW-1:0] cnt;
    logic          conf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = nobody), rotating start, hold age.
  int m_owner, m_ptr, m_hold, m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int start);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (start + k) % N;
      if (r[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_cnt = 0;
  endtask

  task automatic apply(input logic [N-1:0] r, input logic d);
    exp_t e;
    int   ones;
    req  = r;
    done = d;
    ones = $countones(r);
    e.to = 1'b0;
    if (m_owner < 0) begin
      m_owner = pick(r, m_ptr);
      m_hold  = 0;
    end else if (d || !r[m_owner] || m_hold == HOLD - 1) begin
      e.to    = !d && r[m_owner];
      m_ptr   = (m_owner + 1) % N;
      m_owner = pick(r, m_ptr);
      m_hold  = 0;
    end else begin
      m_hold++;
    end
    if (ones >= 2 && m_cnt < CMAX) m_cnt++;
    e.valid = (m_owner >= 0);
    e.grant = e.valid ? N'(1) << m_owner : '0;
    e.idx   = e.valid ? 3'(m_owner) : 3'd0;
    e.cnt   = CW'(m_cnt);
    e.conf  = (ones >= 2);
    q.push_back(e);
  endtask

  task automatic drive(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    apply(r, d);
  endtask

  // Asynchronous reset between clock edges, then release with given inputs.
  task automatic do_reset(input logic [N-1:0] r);
    @(posedge clk);
    #2 arst_n = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_valid", 32'(grant_valid), 0);
    chk("rst_idx", 32'(grant_idx), 0);
    chk("rst_cnt", 32'(conflict_cnt), 0);
    chk("rst_timeout", 32'(timeout), 0);
    req = 5'b00011;
    #1 chk("rst_conflict", 32'(conflict), 1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    apply(r, 1'b0);
  endtask

  always @(posedge clk) begin
    #1;
    if (arst_n && q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("grant", 32'(grant), 32'(e.grant));
      chk("grant_valid", 32'(grant_valid), 32'(e.valid));
      chk("grant_idx", 32'(grant_idx), 32'(e.idx));
      chk("timeout", 32'(timeout), 32'(e.to));
      chk("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
      chk("conflict", 32'(conflict), 32'(e.conf));
    end
  end

  initial begin
    arst_n = 1'b0;
    req    = '0;
    done   = 1'b0;
    model_reset();
    #12;
    chk("por_grant", 32'(grant), 0);
    chk("por_cnt", 32'(conflict_cnt), 0);
    @(negedge clk);
    arst_n = 1'b1;
    apply(5'b10010, 1'b0);

    // Lock on idx1, done hands over to idx4.
    repeat (2) drive(5'b10010, 1'b0);
    drive(5'b10010, 1'b1);
    repeat (2) drive(5'b10010, 1'b0);

    // Full rotation with done every cycle.
    do_reset(5'b11111);
    repeat (7) drive(5'b11111, 1'b1);

    // Sole requester hits the hold limit twice.
    do_reset(5'b00100);
    repeat (10) drive(5'b00100, 1'b0);

    // Drop the owner's request: hand over, then go idle.
    do_reset(5'b01000);
    drive(5'b01000, 1'b0);
    drive(5'b10001, 1'b0);
    drive(5'b01000, 1'b0);
    repeat (2) drive(5'b01000, 1'b0);
    drive(5'b00000, 1'b0);
    drive(5'b00000, 1'b1);

    // Saturation, then reset mid-grant and restart from ptr 0.
    do_reset(5'b00011);
    repeat (20) drive(5'b00011, 1'b0);
    do_reset(5'b11000);
    repeat (3) drive(5'b11000, 1'b0);

    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] r;
      r = req;
      if (i == 200) do_reset(N'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 31));
      drive(r, ($urandom_range(0, 4) == 0));
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
